pattern_gen: RTL
================

// Module: pattern_gen
// PURPOSE
//   Upstream stage of the classic-mode game FSM. While gen_pattern is high, it appends one
//   pseudo-random bit to the stored game pattern and plays the whole pattern to the LED,
//   oldest bit first. It then pulses done_gen_pattern for one cycle.
//   game_pattern/pattern_len feed the comparator and the input handler's expected count.
// PARAMETERS
//   MAX_LEN     16       max pattern length in bits; also game_pattern width
//   ON_CYCLES   4        cycles each bit is shown (>=1)
//   GAP_CYCLES  2        dark cycles after each bit (>=1)
//   SEED        16'hACE1 LFSR reload value on rst/clr; 0 is illegal and is replaced by 16'hACE1
// PORTS
//   clk              in   1        single clock, rising edge
//   rst              in   1        synchronous, active-high reset
//   clr              in   1        synchronous clear from FSM INIT state
//   gen_pattern      in   1        level request from FSM PATTERN_GEN state
//   seed_in          in   16       runtime seed (only with PATTERN_GEN_SEED_EN)
//   game_pattern     out  MAX_LEN  stored pattern, newest bit in [0], right-justified
//   pattern_len      out  $clog2(MAX_LEN+1)  number of valid bits
//   pattern_full     out  1        pattern_len == MAX_LEN
//   led_on           out  1        high while a bit is being shown
//   led_val          out  1        bit being shown; 0 when led_on low
//   done_gen_pattern out  1        one-cycle pulse: round finished
// BEHAVIOUR
//   - Reset (rst=1): state IDLE, game_pattern=0, pattern_len=0, LFSR=SEED, all outputs 0.
//   - Priority: rst > clr > FSM. clr=1: same clear as reset, including LFSR reload.
//     clr aborts playback mid-round with no done pulse.
//   - LFSR: 16-bit Galois, taps 16'hB400, steps once per APPEND; new bit = lfsr[0] after step.
//   - FSM states and transitions:
//     IDLE   : gen_pattern=1 -> APPEND; else stay. done/led outputs 0.
//     APPEND : 1 cycle. Step LFSR. If !pattern_full: game_pattern <= {game_pattern, bit},
//              pattern_len++. If full: no append, pattern unchanged. -> SHOW, idx=pattern_len-1.
//     SHOW   : led_on=1, led_val=game_pattern[idx], for ON_CYCLES cycles -> GAP.
//     GAP    : led_on=0 for GAP_CYCLES cycles; idx==0 -> DONE, else idx--, -> SHOW.
//     DONE   : done_gen_pattern=1 for exactly 1 cycle -> IDLE.
//   - Round latency for length n: 1 + n*(ON_CYCLES+GAP_CYCLES) + 1 cycles from the APPEND
//     entry edge to the end of the done pulse.
//   - gen_pattern is sampled only in IDLE. Dropping it mid-round does not abort the round.
//     Holding it high after DONE starts the next round at once; the FSM leaves
//     PATTERN_GEN on the done pulse, so this does not occur in normal play.
//   - pattern_len saturates at MAX_LEN and never wraps. At saturation each round replays the
//     same pattern and pattern_full stays 1.
//   - One shared cycle counter (width $clog2(max(ON,GAP))) reloads on every SHOW/GAP entry.
// CONFIGURATION
//   PATTERN_GEN_SEED_EN defined: port seed_in exists. rst/clr load LFSR from seed_in
//     (0 -> 16'hACE1), so each game differs.
//   Undefined: no seed_in port; LFSR loads SEED parameter, so patterns are deterministic.
// STRUCTURE
//   Shared package game_pkg: pattern_gen state enum (IDLE, APPEND, SHOW, GAP, DONE),
//   LFSR_TAPS=16'hB400, DEFAULT_SEED=16'hACE1, MAX_LEN default.
//   One sub-module: lfsr16 (clk, rst, load, load_val, step, q), reused later for other modes.
// TESTING (ON_CYCLES=4, GAP_CYCLES=2, SEED=16'hACE1, macro off unless stated)
//   1. rst 1 cycle then gen_pattern=1 -> pattern_len=1, game_pattern[0]=lfsr bit.
//      led_on high 4 cycles, low 2 cycles; done pulse at cycle 8; state IDLE.
//   2. Three rounds -> pattern_len=3; round 3 shows bits [2],[1],[0] in order;
//      done 1+3*6+1=20 cycles after APPEND entry.
//   3. 17 rounds with MAX_LEN=16 -> pattern_len stays 16, pattern_full=1,
//      game_pattern unchanged in round 17, still 16 bits played.
//   4. clr asserted during SHOW of round 2 -> next cycle pattern_len=0, led_on=0,
//      no done pulse; next round reproduces round-1 bit of test 1.
//   5. gen_pattern dropped 1 cycle after APPEND -> round completes, done pulses once.
//   6. Macro on, seed_in=16'h1234 vs 16'h0000 -> seed 0 sequence equals SEED sequence;
//      16'h1234 gives the reference-model LFSR sequence.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared types, constants and LFSR step function for the game datapath blocks.
package game_pkg;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam int          MAX_LEN_DEF  = 16;
   typedef enum logic [2:0] {IDLE, APPEND, SHOW, GAP, DONE} pg_state_e;
   // Right-shifting Galois step: feedback taps are applied when the bit shifted out is 1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR with synchronous load and step enable.
module lfsr16 import game_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        step,
   output logic [15:0] q
);
   logic [15:0] q_q;
   always_ff @(posedge clk) begin
      if (rst || load) q_q <= load_val;
      else if (step)   q_q <= lfsr_next(q_q);
   end
   assign q = q_q;
endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: grows the game pattern by one LFSR bit per round and plays it on the LED.
// Define PATTERN_GEN_SEED_EN to add the seed_in port for a runtime LFSR seed.
module pattern_gen import game_pkg::*; #(
   parameter int          MAX_LEN    = MAX_LEN_DEF,
   parameter int          ON_CYCLES  = 4,
   parameter int          GAP_CYCLES = 2,
   parameter logic [15:0] SEED       = DEFAULT_SEED
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           gen_pattern,
`ifdef PATTERN_GEN_SEED_EN
   input  logic [15:0]                    seed_in,
`endif
   output logic [MAX_LEN-1:0]             game_pattern,
   output logic [$clog2(MAX_LEN+1)-1:0]   pattern_len,
   output logic                           pattern_full,
   output logic                           led_on,
   output logic                           led_val,
   output logic                           done_gen_pattern
);
   localparam int LW = $clog2(MAX_LEN+1);
   localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
   localparam int MC = ON_CYCLES > GAP_CYCLES ? ON_CYCLES : GAP_CYCLES;
   localparam int CW = MC > 1 ? $clog2(MC) : 1;
   localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] TOP_IDX = IW'(MAX_LEN - 1);

   pg_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic [15:0]        seed_raw, seed_val, lfsr_q, lfsr_nx;

`ifdef PATTERN_GEN_SEED_EN
   assign seed_raw = seed_in;
`else
   assign seed_raw = SEED;
`endif
   // An all-zero LFSR would lock up, so a zero seed falls back to the default.
   assign seed_val = (seed_raw == 16'h0000) ? DEFAULT_SEED : seed_raw;
   assign lfsr_nx  = lfsr_next(lfsr_q);

   lfsr16 u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (clr),
      .load_val (seed_val),
      .step     (state_q == APPEND),
      .q        (lfsr_q)
   );

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         pat_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      len_d   = len_q;
      case (state_q)
         IDLE:   state_d = gen_pattern ? APPEND : IDLE;
         APPEND: begin
            if (!pattern_full) begin
               pat_d = {pat_q[MAX_LEN-2:0], lfsr_nx[0]};
               len_d = len_q + 1'b1;
            end
            idx_d   = pattern_full ? TOP_IDX : IW'(len_q);
            cnt_d   = ON_LD;
            state_d = SHOW;
         end
         SHOW: begin
            cnt_d   = (cnt_q == '0) ? GAP_LD : cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? GAP : SHOW;
         end
         GAP: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else if (idx_q == '0) state_d = DONE;
            else begin
               idx_d   = idx_q - 1'b1;
               cnt_d   = ON_LD;
               state_d = SHOW;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign game_pattern     = pat_q;
   assign pattern_len      = len_q;
   assign pattern_full     = (len_q == LW'(MAX_LEN));
   assign led_on           = (state_q == SHOW);
   assign led_val          = led_on & pat_q[idx_q];
   assign done_gen_pattern = (state_q == DONE);
endmodule
